// File: rtl/addsub_pkg.sv
// ============================================================================
// Module      : addsub_pkg
// Description : Shared constants and helpers for the pipelined CLA add/sub.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package addsub_pkg;

  localparam int FLAG_C    = 0;
  localparam int FLAG_V    = 1;
  localparam int FLAG_Z    = 2;
  localparam int FLAG_N    = 3;
  localparam int NUM_FLAGS = 4;

  function automatic int stage_count(input int width, input int slice);
    return width / slice;
  endfunction

  function automatic bit cfg_valid(input int width, input int slice);
    return (slice >= 1) && (width >= slice) && ((width % slice) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cla_slice.sv
// ============================================================================
// Module      : cla_slice
// Description : Combinational SLICE-bit carry-lookahead adder with group P/G.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_slice #(
  parameter int SLICE = 5
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [SLICE-1:0] w_p;
  logic [SLICE-1:0] w_g;
  logic [SLICE-1:0] w_pp;
  logic [SLICE-1:0] w_gg;
  logic [SLICE:0]   w_c;

  function automatic logic [SLICE-1:0] span(input int lo, input int hi);
    logic [SLICE-1:0] m;
    m = '0;
    for (int i = 0; i < SLICE; i++) begin
      m[i] = (i >= lo) && (i <= hi);
    end
    return m;
  endfunction

  assign w_p = a ^ b;
  assign w_g = a & b;

  // w_pp[i]/w_gg[i] are the group propagate/generate over bits [i:0],
  // flattened into sum-of-products so every carry is two levels deep.
  always_comb begin
    w_pp = '0;
    w_gg = '0;
    for (int i = 0; i < SLICE; i++) begin
      w_pp[i] = &(w_p | ~span(0, i));
      for (int j = 0; j <= i; j++) begin
        w_gg[i] = w_gg[i] | (w_g[j] & (&(w_p | ~span(j + 1, i))));
      end
    end
  end

  assign w_c      = {w_gg | (w_pp & {SLICE{cin}}), cin};
  assign sum      = w_p ^ w_c[SLICE-1:0];
  assign c_msb_in = w_c[SLICE-1];
  assign cout     = w_c[SLICE];

endmodule

`default_nettype wire

// File: rtl/pipelined_cla_addsub.sv
// ============================================================================
// Module      : pipelined_cla_addsub
// Description : Pipelined carry-lookahead add/sub, one slice per stage, with
//               valid/ready handshakes. Optional macro ADDSUB_SATURATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_cla_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 20,
  parameter int SLICE = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUB,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             OVF,
  output logic             Zero,
  output logic             Neg
);

  localparam int N = stage_count(WIDTH, SLICE);

  if (!cfg_valid(WIDTH, SLICE)) begin : g_cfg_check
    $error("pipelined_cla_addsub: WIDTH must be a non-zero multiple of SLICE");
  end

  logic                 w_advance;
  logic [WIDTH-1:0]     w_beff;

  // Per-stage state; index N-1 of r_sum is the registered Sum output.
  logic                 r_vld  [N];
  logic                 r_cout [N];
  logic [WIDTH-1:0]     r_a    [N];
  logic [WIDTH-1:0]     r_b    [N];
  logic [WIDTH-1:0]     r_sum  [N];
  logic [NUM_FLAGS-1:0] r_flags;

  logic [SLICE-1:0]     w_sl_a    [N];
  logic [SLICE-1:0]     w_sl_b    [N];
  logic [SLICE-1:0]     w_sl_sum  [N];
  logic                 w_sl_cin  [N];
  logic                 w_sl_cout [N];
  logic                 w_sl_cmsb [N];

  assign w_advance = !r_vld[N-1] || OUT_READY;
  assign IN_READY  = w_advance;
  assign w_beff    = SUB ? ~B : B;

  for (genvar k = 0; k < N; k++) begin : g_stage
    logic             w_vin;
    logic [WIDTH-1:0] w_sum_prev;
    logic [WIDTH-1:0] w_sum_word;

    if (k == 0) begin : g_first
      assign w_vin       = IN_VALID;
      assign w_sum_prev  = '0;
      assign w_sl_a[k]   = A[SLICE-1:0];
      assign w_sl_b[k]   = w_beff[SLICE-1:0];
      assign w_sl_cin[k] = SUB;
    end else begin : g_next
      assign w_vin       = r_vld[k-1];
      assign w_sum_prev  = r_sum[k-1];
      assign w_sl_a[k]   = r_a[k-1][k*SLICE +: SLICE];
      assign w_sl_b[k]   = r_b[k-1][k*SLICE +: SLICE];
      assign w_sl_cin[k] = r_cout[k-1];
    end

    cla_slice #(
      .SLICE    (SLICE)
    ) u_slice (
      .a        (w_sl_a[k]),
      .b        (w_sl_b[k]),
      .cin      (w_sl_cin[k]),
      .sum      (w_sl_sum[k]),
      .cout     (w_sl_cout[k]),
      .c_msb_in (w_sl_cmsb[k])
    );

    always_comb begin
      w_sum_word                    = w_sum_prev;
      w_sum_word[k*SLICE +: SLICE]  = w_sl_sum[k];
    end

    if (k < N - 1) begin : g_mid
      always_ff @(posedge CLK) begin
        if (RST) begin
          r_vld[k] <= 1'b0;
        end else if (w_advance) begin
          r_vld[k] <= w_vin;
        end
        if (w_advance) begin
          r_sum[k]  <= w_sum_word;
          r_cout[k] <= w_sl_cout[k];
          if (k == 0) begin
            r_a[k] <= A;
            r_b[k] <= w_beff;
          end else begin
            r_a[k] <= r_a[(k == 0) ? 0 : k - 1];
            r_b[k] <= r_b[(k == 0) ? 0 : k - 1];
          end
        end
      end
    end else begin : g_last
      logic             w_ovf;
      logic [WIDTH-1:0] w_final;

      assign w_ovf = w_sl_cout[k] ^ w_sl_cmsb[k];

`ifdef ADDSUB_SATURATE_EN
      // On overflow the true sign equals A's sign for both add and subtract.
      assign w_final = !w_ovf          ? w_sum_word :
                       w_sl_a[k][SLICE-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                          {1'b0, {(WIDTH-1){1'b1}}};
`else
      assign w_final = w_sum_word;
`endif

      // Output registers only load real results, so bubbles leave them intact.
      always_ff @(posedge CLK) begin
        if (RST) begin
          r_vld[k] <= 1'b0;
          r_sum[k] <= '0;
          r_flags  <= '0;
        end else if (w_advance) begin
          r_vld[k] <= w_vin;
          if (w_vin) begin
            r_sum[k]         <= w_final;
            r_flags[FLAG_C]  <= w_sl_cout[k];
            r_flags[FLAG_V]  <= w_ovf;
            r_flags[FLAG_Z]  <= (w_final == '0);
            r_flags[FLAG_N]  <= w_final[WIDTH-1];
          end
        end
      end
    end
  end

  assign OUT_VALID = r_vld[N-1];
  assign Sum       = r_sum[N-1];
  assign Carry     = r_flags[FLAG_C];
  assign OVF       = r_flags[FLAG_V];
  assign Zero      = r_flags[FLAG_Z];
  assign Neg       = r_flags[FLAG_N];

endmodule

`default_nettype wire

// File: tb/tb_pipelined_cla_addsub.sv
// ============================================================================
// Module      : tb_pipelined_cla_addsub
// Description : Directed self-checking bench for pipelined_cla_addsub
//               (expected values follow ADDSUB_SATURATE_EN when defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_cla_addsub;

  localparam int WIDTH = 20;
  localparam int SLICE = 5;
  localparam int LAT   = 4;
`ifdef ADDSUB_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RST;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             SUB;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] Sum;
  logic             Carry;
  logic             OVF;
  logic             Zero;
  logic             Neg;
  logic [3:0]       obs_flags;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic [WIDTH-1:0] s;
    logic [3:0]       f;   // {C, V, Z, N}
  } vec_t;

  always #5 CLK = ~CLK;

  assign obs_flags = {Carry, OVF, Zero, Neg};

  pipelined_cla_addsub #(
    .WIDTH     (WIDTH),
    .SLICE     (SLICE)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .SUB       (SUB),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .Sum       (Sum),
    .Carry     (Carry),
    .OVF       (OVF),
    .Zero      (Zero),
    .Neg       (Neg)
  );

  // Drives one operand transfer and returns at the first negedge with
  // OUT_VALID high; lat counts rising edges from the transfer edge onward.
  task automatic send_one(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sub, output int lat);
    @(negedge CLK);
    A = a; B = b; SUB = sub; IN_VALID = 1'b1; OUT_READY = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    lat = 1;
    while (!OUT_VALID && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0; A = '0; B = '0; SUB = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    n_checks++;
    if (OUT_VALID !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b want 0", OUT_VALID);
    end
    n_checks++;
    if (Sum !== '0 || obs_flags !== 4'b0000) begin
      n_fail++; $display("FAIL reset_outputs: got sum %h flags %b want 0 0000", Sum, obs_flags);
    end
    RST = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (IN_READY !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", IN_READY);
    end
  endtask

  task automatic test_add();
    int lat;
    logic [WIDTH-1:0] es;
    logic [3:0]       ef;
    es = SAT ? 20'h7FFFF : 20'hDBA86;
    ef = SAT ? 4'b0100   : 4'b0101;
    send_one(20'h7FFC2, 20'h5BAC4, 1'b0, lat);
    n_checks++;
    if (lat !== LAT) begin
      n_fail++; $display("FAIL add_latency: got %0d want %0d", lat, LAT);
    end
    n_checks++;
    if (Sum !== es) begin
      n_fail++; $display("FAIL add_sum: got %h want %h", Sum, es);
    end
    n_checks++;
    if (obs_flags !== ef) begin
      n_fail++; $display("FAIL add_flags: got %b want %b", obs_flags, ef);
    end
  endtask

  task automatic test_sub();
    int lat;
    send_one(20'h4851A, 20'hD151A, 1'b1, lat);
    n_checks++;
    if (Sum !== 20'h77000) begin
      n_fail++; $display("FAIL sub_sum: got %h want 77000", Sum);
    end
    n_checks++;
    if (obs_flags !== 4'b0000) begin
      n_fail++; $display("FAIL sub_flags: got %b want 0000", obs_flags);
    end
  endtask

  task automatic test_equal();
    int lat;
    send_one(20'h12345, 20'h12345, 1'b1, lat);
    n_checks++;
    if (Sum !== 20'h00000) begin
      n_fail++; $display("FAIL equal_sum: got %h want 00000", Sum);
    end
    n_checks++;
    if (obs_flags !== 4'b1010) begin
      n_fail++; $display("FAIL equal_flags: got %b want 1010", obs_flags);
    end
  endtask

  task automatic test_most_negative();
    int lat;
    logic [WIDTH-1:0] es;
    logic [3:0]       ef;
    es = SAT ? 20'h80000 : 20'h7FFFF;
    ef = SAT ? 4'b1101   : 4'b1100;
    send_one(20'h80000, 20'h00001, 1'b1, lat);
    n_checks++;
    if (Sum !== es) begin
      n_fail++; $display("FAIL mostneg_sum: got %h want %h", Sum, es);
    end
    n_checks++;
    if (obs_flags !== ef) begin
      n_fail++; $display("FAIL mostneg_flags: got %b want %b", obs_flags, ef);
    end
  endtask

  task automatic test_back_to_back();
    vec_t v [8];
    int   tx, rx, cyc, stalls;
    v[0] = '{20'h00001, 20'h00002, 1'b0, 20'h00003, 4'b0000};
    v[1] = '{20'h00010, 20'h00003, 1'b1, 20'h0000D, 4'b1000};
    v[2] = '{20'hFFFFF, 20'h00001, 1'b0, 20'h00000, 4'b1010};
    v[3] = '{20'h00000, 20'h00001, 1'b1, 20'hFFFFF, 4'b0001};
    v[4] = '{20'h7FFFF, 20'h00001, 1'b0, SAT ? 20'h7FFFF : 20'h80000,
             SAT ? 4'b0100 : 4'b0101};
    v[5] = '{20'h12345, 20'h54321, 1'b0, 20'h66666, 4'b0000};
    v[6] = '{20'h80000, 20'h80000, 1'b0, SAT ? 20'h80000 : 20'h00000,
             SAT ? 4'b1101 : 4'b1110};
    v[7] = '{20'h0ABCD, 20'h0ABCD, 1'b1, 20'h00000, 4'b1010};
    tx = 0; rx = 0; cyc = 0; stalls = 0;
    while (rx < 8 && cyc < 100) begin
      @(negedge CLK);
      OUT_READY = !(cyc >= 6 && cyc < 11);
      if (tx < 8) begin
        A = v[tx].a; B = v[tx].b; SUB = v[tx].sub; IN_VALID = 1'b1;
      end else begin
        IN_VALID = 1'b0;
      end
      #1;
      if (OUT_VALID) begin
        n_checks++;
        if (Sum !== v[rx].s) begin
          n_fail++; $display("FAIL b2b_sum[%0d]: got %h want %h", rx, Sum, v[rx].s);
        end
        n_checks++;
        if (obs_flags !== v[rx].f) begin
          n_fail++; $display("FAIL b2b_flags[%0d]: got %b want %b", rx, obs_flags, v[rx].f);
        end
        if (!OUT_READY) begin
          stalls++;
          n_checks++;
          if (IN_READY !== 1'b0) begin
            n_fail++; $display("FAIL b2b_in_ready_stall: got %b want 0", IN_READY);
          end
        end else begin
          rx++;
        end
      end
      if (IN_VALID && IN_READY) tx++;
      cyc++;
    end
    IN_VALID = 1'b0;
    n_checks++;
    if (rx !== 8 || tx !== 8) begin
      n_fail++; $display("FAIL b2b_count: got rx %0d tx %0d want 8 8", rx, tx);
    end
    n_checks++;
    if (stalls !== 5) begin
      n_fail++; $display("FAIL b2b_stall_cycles: got %0d want 5", stalls);
    end
    @(negedge CLK);
    n_checks++;
    if (OUT_VALID !== 1'b0) begin
      n_fail++; $display("FAIL b2b_extra_result: got %b want 0", OUT_VALID);
    end
  endtask

  task automatic test_reset_midstream();
    int stale;
    int lat;
    @(negedge CLK);
    OUT_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      A = 20'h00100 + 20'(i); B = 20'h00011; SUB = 1'b0; IN_VALID = 1'b1;
      @(negedge CLK);
    end
    IN_VALID = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (OUT_VALID !== 1'b0) begin
      n_fail++; $display("FAIL midrst_out_valid: got %b want 0", OUT_VALID);
    end
    n_checks++;
    if (Sum !== '0 || obs_flags !== 4'b0000) begin
      n_fail++; $display("FAIL midrst_outputs: got sum %h flags %b want 0 0000", Sum, obs_flags);
    end
    RST = 1'b0;
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (OUT_VALID) stale++;
    end
    n_checks++;
    if (stale !== 0) begin
      n_fail++; $display("FAIL midrst_stale: got %0d stale cycles want 0", stale);
    end
    send_one(20'h00020, 20'h00005, 1'b1, lat);
    n_checks++;
    if (Sum !== 20'h0001B || lat !== LAT) begin
      n_fail++; $display("FAIL midrst_recover: got sum %h lat %0d want 0001b %0d", Sum, lat, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_equal();
    test_most_negative();
    test_back_to_back();
    test_add();
    test_most_negative();
    test_reset_midstream();
    repeat (2) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipelined_cla_addsub.md
# pipelined_cla_addsub

Parametrised, pipelined carry-lookahead adder/subtractor, the next generation of the team's fixed 20-bit combinational CLA add/sub. The operand width is split into equal slices. One slice is resolved per pipeline stage, with the carry registered between stages. Operands enter and results leave through valid/ready handshakes, so the block can sit directly in a streaming datapath with backpressure. Each result carries Carry, OVF, Zero and Neg flags.

## Interface
- WIDTH, 20: operand/result width in bits; must be a multiple of SLICE.
- SLICE, 5: bits resolved per pipeline stage; stage count N = WIDTH/SLICE, N ≥ 1.
- CLK  input  1  rising-edge clock; the only clock.
- RST  input  1  reset, synchronous and active-high.
- IN_VALID  input  1  A/B/SUB are valid this cycle.
- IN_READY  output  1  block accepts operands this cycle.
- A  input  WIDTH  operand A, two's complement.
- B  input  WIDTH  operand B, two's complement.
- SUB  input  1  0 = A+B, 1 = A−B.
- OUT_VALID  output  1  Sum and flags are valid.
- OUT_READY  input  1  downstream accepts the result.
- Sum  output  WIDTH  result.
- Carry  output  1  carry out of the MSB; for SUB, 1 = no borrow.
- OVF  output  1  signed overflow.
- Zero  output  1  Sum == 0.
- Neg  output  1  Sum[WIDTH-1].

## Operation
- Transfers:
  - An operand transfer happens when IN_VALID && IN_READY.
  - A result transfer happens when OUT_VALID && OUT_READY.
- Arithmetic:
  - Beff = SUB ? ~B : B.
  - Carry-in to slice 0 = SUB.
  - Slice k computes bits [k*SLICE +: SLICE] from A, Beff and the registered carry out of slice k−1.
- Skew/deskew:
  - Unprocessed operand slices travel forward in skew registers.
  - Finished Sum slices travel forward in deskew registers.
  - All slices of a result emerge aligned.
- Flags:
  - Carry = carry out of the MSB.
  - OVF = carry into the MSB XOR carry out of the MSB.
  - Zero and Neg are computed on the final Sum, after saturation if it is compiled in.
- Pipeline control:
  - Global stall: advance = !OUT_VALID || OUT_READY.
  - IN_READY = advance; this is a combinational path from OUT_READY, which is permitted.
  - Each stage holds a valid bit. Bubbles propagate and are not collapsed.
  - A stalled OUT_VALID holds Sum and all flags stable until accepted.
- No FSM: state is the per-stage valid bits plus the data, carry and skew registers.
- SUB is latched per transaction, so mixed add/sub streams are legal back to back.

## Timing
- Latency: N cycles from operand transfer to OUT_VALID, with no stall. For the default configuration N = 4.
- Throughput: one result per cycle while OUT_READY is held high.
- Reset:
  - All valid bits clear, so OUT_VALID = 0.
  - Sum, Carry, OVF, Zero and Neg = 0.
  - IN_READY = 1 in the first cycle after RST deasserts.
- RST mid-operation: every in-flight transaction is discarded and no partial result is ever presented.
- Simultaneous input and output transfer in the same cycle is legal when advance = 1.
- N = 1 (SLICE = WIDTH): a single registered stage with the same handshake rules.
- Corner cases:
  - A = B with SUB = 1 gives Sum 0, Carry 1, Zero 1.
  - Most-negative minus 1 overflows (OVF = 1).

## Configuration
- ADDSUB_SATURATE_EN:
  - Defined: when OVF = 1, Sum is clamped to the signed limit. The limit is 0x7…F if the true result is positive (A sign = 0 for add), otherwise 0x8…0. OVF is still reported as 1. The clamp is applied in the last stage, so latency is unchanged.
  - Undefined: Sum wraps modulo 2^WIDTH.

## Structure
- Package addsub_pkg:
  - Flag index constants (FLAG_C, FLAG_V, FLAG_Z, FLAG_N).
  - A function computing the stage count from WIDTH/SLICE.
  - An elaboration check that WIDTH % SLICE == 0.
- Sub-module cla_slice:
  - Combinational, SLICE-bit lookahead using group P/G.
  - Ports: a, b, cin, sum, cout, and c_msb_in (the carry into the slice MSB, used for OVF).
  - Instantiated N times in a generate loop.

## Test plan
- Add, WIDTH=20 SLICE=5: A=0x7FFC2, B=0x5BAC4, SUB=0 → after 4 cycles Sum=0xDBA86, Carry=0, OVF=1, Neg=1.
- Subtract: A=0x4851A, B=0xD151A, SUB=1 → Sum=0x77000, Carry=0, OVF=0, Zero=0.
- Equal operands: A=B=0x12345, SUB=1 → Sum=0, Carry=1, Zero=1, OVF=0.
- Backpressure:
  - Stimulus: stream 8 mixed add/sub transactions back to back, hold OUT_READY=0 for 5 cycles mid-stream.
  - Required: results in order, none lost or duplicated; outputs stable while stalled; IN_READY=0 during the stall.
- Reset mid-stream: assert RST with 3 transactions in flight → OUT_VALID=0 and all outputs 0 next cycle; no stale result appears afterwards.
- With ADDSUB_SATURATE_EN: repeat case 1 → Sum=0x7FFFF, OVF=1; A=0x80000, B=0x00001, SUB=1 → Sum=0x80000, OVF=1.
